mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between the instruction-fetch port and the load/store data port of the RV32I pipeline.
- Registered FSM grants one requester per transaction, holds the bus until acknowledge or timeout, then returns read data with a one-cycle ready pulse.
- Data accesses have priority over fetch; a starvation counter guarantees fetch progress.
- The pipeline stalls on the per-port ready signals.

Parameters:
- MAX_STARVE, 4, consecutive data grants allowed while fetch waits before fetch is forced to win.
- TIMEOUT, 16, cycles in a BUSY state without mem_ack before the transaction is aborted with an error.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  32  fetch address (word aligned).
- if_rdata  out  32  fetched instruction, valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_req  in  1  data request (load or store); held until dm_ready.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  32  data address.
- dm_wdata  in  32  store data.
- dm_be  in  4  byte enables.
- dm_rdata  out  32  load data, valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse for data.
- bus_err  out  1  qualifies the current ready pulse as a timeout abort.
- mem_req  out  1  memory request, held high until ack or abort.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables; 4'hF for fetch.
- mem_rdata  in  32  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, single cycle.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ready, dm_ready, if_rdata, dm_rdata, bus_err.
  - starve_cnt=0, wait_cnt=0.
  - Reset asserted mid-transaction abandons it; no ready pulse is produced.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE:
  - A port is eligible if its req=1 and its ready is not asserted this cycle.
  - If both ports are eligible: BUSY_I when starve_cnt==MAX_STARVE, otherwise BUSY_D.
  - If only one is eligible, go to its BUSY state; if none, stay in IDLE.
  - On the transition, register mem_addr/mem_we/mem_wdata/mem_be from the granted port and set mem_req=1 next cycle.
  - For fetch, mem_we=0 and mem_be=4'hF.
- BUSY_x:
  - mem_* outputs stay constant; wait_cnt increments each cycle.
  - On mem_ack: mem_req=0 next cycle; the granted port's ready=1 for exactly one cycle; rdata is registered from mem_rdata (loads and fetch); return to IDLE.
  - Store completions drive dm_rdata=0.
- Timeout: wait_cnt reaches TIMEOUT-1 with no ack → mem_req drops, ready pulses with bus_err=1, rdata=0, return to IDLE.
- A mem_ack arriving in IDLE is ignored.
- Minimum latency: req at cycle N, mem_req at N+1, ack at N+1, ready at N+2. Back-to-back transactions are spaced 2 cycles apart.
- starve_cnt:
  - Increments (saturating at MAX_STARVE) when data is granted while if_req=1.
  - Clears when fetch is granted.
  - Unchanged otherwise.
- rdata outputs hold their last value when ready=0.
- Requester protocol violations (req dropped before ready) are not detected. The bus transaction completes and the ready pulse is still issued.

Decomposition:
- Shared package rv32_mem_pkg holds:
  - arb_state_t enum (IDLE, BUSY_I, BUSY_D).
  - BE_WORD = 4'hF.
  - Default MAX_STARVE and TIMEOUT constants.
- Single module. The saturating starve/wait counters are small enough to stay inline; no sub-module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, mem_ack one cycle after mem_req with mem_rdata=0x00500093 → mem_addr=0x100, mem_be=4'hF; if_ready pulses once with if_rdata=0x00500093 two cycles after if_req.
- Simultaneous: if_req and dm_req (store, addr 0x2000, wdata 0xDEADBEEF, be 4'b0011) in the same cycle → data is served first with mem_we=1, then fetch; dm_ready precedes if_ready.
- Starvation: dm_req held continuously with if_req=1 and MAX_STARVE=4 → exactly 4 data grants, then a fetch grant, then starve_cnt=0.
- Timeout: a grant with mem_ack held at 0 → after 16 BUSY cycles mem_req drops, and the ready pulse has bus_err=1 and rdata=0.
- Reset mid-transaction: rst_n low during BUSY_D → all outputs 0 immediately; a later stray mem_ack causes no ready pulse.
- Load data path: dm_we=0, addr 0x3004, mem_rdata=0x12345678 → dm_rdata=0x12345678 with dm_ready=1 for exactly one cycle, and bus_err=0.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared types and defaults for the unified memory-port arbiter.
package rv32_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam logic [3:0]  BE_WORD        = 4'hF;
  localparam int unsigned MAX_STARVE_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and memory bus of the arbiter in one bundle.
// slave: the arbiter's view; master: the pipeline and memory surrounding it.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_ready;

  logic        bus_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready, bus_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Grants the fetch or load/store port one memory transaction at a time; data wins
// unless fetch has been passed over MAX_STARVE times. Stuck transactions time out.
module mem_port_arbiter
  import rv32_mem_pkg::*;
#(
  parameter int unsigned MAX_STARVE = MAX_STARVE_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned   SW         = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
  localparam int unsigned   WW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_STARVE);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  arb_state_t    state, state_nx;
  logic [SW-1:0] starve_cnt, starve_nx;
  logic [WW-1:0] wait_cnt, wait_nx;

  logic          mem_req_q, mem_req_nx;
  logic          mem_we_q, mem_we_nx;
  logic [31:0]   mem_addr_q, mem_addr_nx;
  logic [31:0]   mem_wdata_q, mem_wdata_nx;
  logic [3:0]    mem_be_q, mem_be_nx;
  logic          if_ready_q, if_ready_nx;
  logic          dm_ready_q, dm_ready_nx;
  logic          bus_err_q, bus_err_nx;
  logic [31:0]   if_rdata_q, if_rdata_nx;
  logic [31:0]   dm_rdata_q, dm_rdata_nx;

  logic          if_elig, dm_elig, grant_i, grant_d, done;

  always_comb begin
    state_nx     = state;
    starve_nx    = starve_cnt;
    wait_nx      = wait_cnt;
    mem_req_nx   = mem_req_q;
    mem_we_nx    = mem_we_q;
    mem_addr_nx  = mem_addr_q;
    mem_wdata_nx = mem_wdata_q;
    mem_be_nx    = mem_be_q;
    if_ready_nx  = 1'b0;
    dm_ready_nx  = 1'b0;
    bus_err_nx   = 1'b0;
    if_rdata_nx  = if_rdata_q;
    dm_rdata_nx  = dm_rdata_q;
    // A port whose ready is high this cycle is still holding its finished request.
    if_elig      = bus.if_req && !if_ready_q;
    dm_elig      = bus.dm_req && !dm_ready_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        grant_i = if_elig && (!dm_elig || starve_cnt == STARVE_LIM);
        grant_d = dm_elig && !grant_i;
        if (grant_i) begin
          state_nx     = BUSY_I;
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = bus.if_addr;
          mem_wdata_nx = '0;
          mem_be_nx    = BE_WORD;
          wait_nx      = '0;
          starve_nx    = '0;
        end else if (grant_d) begin
          state_nx     = BUSY_D;
          mem_req_nx   = 1'b1;
          mem_we_nx    = bus.dm_we;
          mem_addr_nx  = bus.dm_addr;
          mem_wdata_nx = bus.dm_wdata;
          mem_be_nx    = bus.dm_be;
          wait_nx      = '0;
          if (bus.if_req && starve_cnt != STARVE_LIM) starve_nx = starve_cnt + 1'b1;
        end
      end

      BUSY_I, BUSY_D: begin
        done = bus.mem_ack || (wait_cnt == WAIT_LAST);
        if (done) begin
          state_nx   = IDLE;
          mem_req_nx = 1'b0;
          bus_err_nx = !bus.mem_ack;
          if (state == BUSY_I) begin
            if_ready_nx = 1'b1;
            if_rdata_nx = bus.mem_ack ? bus.mem_rdata : '0;
          end else begin
            dm_ready_nx = 1'b1;
            dm_rdata_nx = (bus.mem_ack && !mem_we_q) ? bus.mem_rdata : '0;
          end
        end else begin
          wait_nx = wait_cnt + 1'b1;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state       <= state_nx;
      starve_cnt  <= starve_nx;
      wait_cnt    <= wait_nx;
      mem_req_q   <= mem_req_nx;
      mem_we_q    <= mem_we_nx;
      mem_addr_q  <= mem_addr_nx;
      mem_wdata_q <= mem_wdata_nx;
      mem_be_q    <= mem_be_nx;
      if_ready_q  <= if_ready_nx;
      dm_ready_q  <= dm_ready_nx;
      bus_err_q   <= bus_err_nx;
      if_rdata_q  <= if_rdata_nx;
      dm_rdata_q  <= dm_rdata_nx;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, checked
// by a negedge monitor against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  import rv32_mem_pkg::*;

  localparam int unsigned MAX_STARVE = 4;
  localparam int unsigned TIMEOUT    = 16;

  logic clk = 1'b0;
  logic rst_n;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    $display("FAIL %s: event missing", name);
  endtask

  // Memory responses scheduled by the responder; popped by the monitor on ready.
  typedef struct packed {
    logic [31:0] rdata;
    logic        timeout;
  } resp_t;
  resp_t q_mem[$];

  // Stimulus controls
  bit          auto_en, stray_en, stray_force, forced_rdata_en;
  int          forced_delay;
  logic [31:0] forced_rdata;
  int unsigned req_pct;
  int          busy_idx, delay;
  logic [31:0] rsp_data;

  task automatic drive_ports();
    if (bus.if_req) begin
      if (bus.if_ready) begin
        bus.if_req = ($urandom_range(99) < req_pct);
        bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end
    end else if ($urandom_range(99) < req_pct) begin
      bus.if_req  = 1'b1;
      bus.if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!bus.dm_req || bus.dm_ready) begin
      if (!bus.dm_req || bus.dm_ready) bus.dm_req = ($urandom_range(99) < req_pct);
      bus.dm_we    = $urandom_range(1);
      bus.dm_addr  = $urandom;
      bus.dm_wdata = $urandom;
      bus.dm_be    = 4'($urandom_range(15));
    end
  endtask

  task automatic respond();
    resp_t r;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    if (bus.mem_req) begin
      if (busy_idx == 0) begin
        if (forced_delay >= 0) delay = forced_delay;
        else delay = ($urandom_range(9) == 0) ? 99 : int'($urandom_range(3));
        rsp_data  = forced_rdata_en ? forced_rdata : $urandom;
        r.rdata   = rsp_data;
        r.timeout = (delay >= int'(TIMEOUT));
        q_mem.push_back(r);
      end
      if (busy_idx == delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rsp_data;
      end
      busy_idx++;
    end else begin
      busy_idx = 0;
      if (stray_force || (stray_en && $urandom_range(7) == 0)) bus.mem_ack = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (auto_en) drive_ports();
    respond();
  endtask

  task automatic wait_ready(input bit want_if, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(want_if ? bus.if_ready : bus.dm_ready) && n < 40);
    if (!(want_if ? bus.if_ready : bus.dm_ready)) note_fail(want_if ? "if_ready_timeout" : "dm_ready_timeout");
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_req"},   bus.mem_req,   '0);
    check({tag, "_mem_we"},    bus.mem_we,    '0);
    check({tag, "_mem_addr"},  bus.mem_addr,  '0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    check({tag, "_mem_be"},    bus.mem_be,    '0);
    check({tag, "_if_ready"},  bus.if_ready,  '0);
    check({tag, "_dm_ready"},  bus.dm_ready,  '0);
    check({tag, "_if_rdata"},  bus.if_rdata,  '0);
    check({tag, "_dm_rdata"},  bus.dm_rdata,  '0);
    check({tag, "_bus_err"},   bus.bus_err,   '0);
  endtask

  // Reference model: who owns the bus, for how long, and how often fetch lost.
  logic        m_busy, m_port_i, m_we;
  int unsigned m_cycles, m_starve;
  logic [31:0] m_addr, m_wdata, m_last_if, m_last_dm;
  logic [3:0]  m_be;
  logic        p_if_req, p_dm_req, p_if_ready, p_dm_ready, p_mem_ack, p_dm_we;
  logic [31:0] p_if_addr, p_dm_addr, p_dm_wdata;
  logic [3:0]  p_dm_be;

  always @(negedge clk) begin : monitor
    logic        end_now, exp_if_rdy, exp_dm_rdy, el_i, el_d, win_i;
    logic [31:0] exp_rd;
    resp_t       r;
    if (!rst_n) begin
      m_busy = 1'b0; m_starve = 0; m_last_if = '0; m_last_dm = '0;
      q_mem.delete();
      p_if_req = 1'b0; p_dm_req = 1'b0; p_if_ready = 1'b0; p_dm_ready = 1'b0; p_mem_ack = 1'b0;
    end else begin
      end_now = 1'b0;
      if (m_busy) begin
        if (p_mem_ack || m_cycles == TIMEOUT) end_now = 1'b1;
        else m_cycles++;
      end
      exp_if_rdy = end_now && m_port_i;
      exp_dm_rdy = end_now && !m_port_i;
      check("if_ready", bus.if_ready, exp_if_rdy);
      check("dm_ready", bus.dm_ready, exp_dm_rdy);

      if (bus.if_ready || bus.dm_ready) begin
        if (q_mem.size() == 0) note_fail("resp_queue");
        else begin
          r = q_mem.pop_front();
          exp_rd = (r.timeout || (!m_port_i && m_we)) ? 32'h0 : r.rdata;
          if (bus.if_ready) begin check("if_rdata", bus.if_rdata, exp_rd); m_last_if = exp_rd; end
          else begin check("dm_rdata", bus.dm_rdata, exp_rd); m_last_dm = exp_rd; end
          check("bus_err", bus.bus_err, r.timeout);
        end
      end else check("bus_err_quiet", bus.bus_err, 1'b0);
      if (!bus.if_ready) check("if_rdata_hold", bus.if_rdata, m_last_if);
      if (!bus.dm_ready) check("dm_rdata_hold", bus.dm_rdata, m_last_dm);

      if (end_now) begin
        m_busy = 1'b0;
        check("mem_req_drop", bus.mem_req, 1'b0);
      end else if (m_busy) begin
        check("busy_mem_req", bus.mem_req, 1'b1);
        check("busy_mem_addr", bus.mem_addr, m_addr);
        check("busy_mem_we", bus.mem_we, m_we);
        check("busy_mem_be", bus.mem_be, m_be);
        if (!m_port_i) check("busy_mem_wdata", bus.mem_wdata, m_wdata);
      end else begin
        el_i = p_if_req && !p_if_ready;
        el_d = p_dm_req && !p_dm_ready;
        check("grant_mem_req", bus.mem_req, el_i || el_d);
        if (el_i || el_d) begin
          win_i = el_i && (!el_d || m_starve == MAX_STARVE);
          if (win_i) begin
            m_addr = p_if_addr; m_we = 1'b0; m_be = BE_WORD; m_starve = 0;
          end else begin
            m_addr = p_dm_addr; m_we = p_dm_we; m_be = p_dm_be; m_wdata = p_dm_wdata;
            if (p_if_req && m_starve < MAX_STARVE) m_starve++;
          end
          m_port_i = win_i; m_busy = 1'b1; m_cycles = 1;
          check("grant_port_we", bus.mem_we, m_we);
          check("grant_addr", bus.mem_addr, m_addr);
          check("grant_be", bus.mem_be, m_be);
          if (!win_i) check("grant_wdata", bus.mem_wdata, m_wdata);
        end
      end

      p_if_req = bus.if_req;   p_if_addr = bus.if_addr;
      p_dm_req = bus.dm_req;   p_dm_we = bus.dm_we;   p_dm_addr = bus.dm_addr;
      p_dm_wdata = bus.dm_wdata; p_dm_be = bus.dm_be;
      p_mem_ack = bus.mem_ack;
      p_if_ready = exp_if_rdy; p_dm_ready = exp_dm_rdy;
    end
  end

  initial begin
    int n, di, ii, cnt;
    rst_n = 1'b0;
    auto_en = 1'b0; stray_en = 1'b0; stray_force = 1'b0; forced_rdata_en = 1'b0;
    forced_delay = -1; forced_rdata = '0; req_pct = 0; busy_idx = 0; delay = 0; rsp_data = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) cycle();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    cycle();

    // Fetch only
    forced_delay = 0; forced_rdata_en = 1'b1; forced_rdata = 32'h0050_0093;
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    wait_ready(1'b1, n);
    check("fetch_latency", n, 2);
    check("fetch_rdata_direct", bus.if_rdata, 32'h0050_0093);
    bus.if_req = 1'b0;
    cycle();
    check("fetch_ready_single", bus.if_ready, 1'b0);

    // Simultaneous store and fetch: data first
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2000;
    bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_be = 4'b0011;
    di = 0; ii = 0;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      if (bus.dm_ready && di == 0) begin di = c; bus.dm_req = 1'b0; end
      if (bus.if_ready && ii == 0) begin ii = c; bus.if_req = 1'b0; end
    end
    check("simul_dm_cycle", di, 2);
    check("simul_if_cycle", ii, 4);

    // Load data path
    forced_rdata = 32'h1234_5678;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h3004; bus.dm_be = 4'hF;
    wait_ready(1'b0, n);
    check("load_latency", n, 2);
    check("load_rdata_direct", bus.dm_rdata, 32'h1234_5678);
    check("load_bus_err", bus.bus_err, 1'b0);
    bus.dm_req = 1'b0;
    cycle();
    check("load_ready_single", bus.dm_ready, 1'b0);

    // Timeout
    forced_delay = 99;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h40;
    wait_ready(1'b0, n);
    check("timeout_latency", n, 17);
    check("timeout_err", bus.bus_err, 1'b1);
    check("timeout_rdata", bus.dm_rdata, 32'h0);
    bus.dm_req = 1'b0;
    cycle();
    check("timeout_mem_req_low", bus.mem_req, 1'b0);
    check("timeout_err_single", bus.bus_err, 1'b0);

    // Saturated contention, then mixed random traffic with stray acks
    forced_delay = -1; forced_rdata_en = 1'b0;
    auto_en = 1'b1; req_pct = 100;
    repeat (200) cycle();
    req_pct = 40; stray_en = 1'b1;
    repeat (3000) cycle();
    req_pct = 0;
    repeat (60) cycle();
    auto_en = 1'b0; stray_en = 1'b0;
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    repeat (3) cycle();

    // Reset in the middle of a data transaction
    forced_delay = 99;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h5000;
    bus.dm_wdata = 32'hA5A5_5A5A; bus.dm_be = 4'hC;
    n = 0;
    do begin cycle(); n++; end while (!bus.mem_req && n < 10);
    if (!bus.mem_req) note_fail("midreset_grant");
    cycle();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    bus.dm_req = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    stray_force = 1'b1;
    cycle();
    stray_force = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      cycle();
      if (bus.if_ready || bus.dm_ready) cnt++;
    end
    check("stray_ack_no_ready", cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
